// File: rtl/uart_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// axi4 : AXI4 bus bundle used by the UART-to-AXI bridge.
//
// Parameter
//   idlen : width of the AXI ID fields (aw_id, b_id, ar_id, r_id).
//
// Channels (all signals plain logic, single-beat 32-bit data path)
//   AW : aw_valid, aw_ready, aw_addr[31:0], aw_id, aw_len[7:0],
//        aw_size[2:0], aw_burst[1:0]
//   W  : w_valid, w_ready, w_data[31:0], w_strb[3:0], w_last
//   B  : b_valid, b_ready, b_id, b_resp[1:0]
//   AR : ar_valid, ar_ready, ar_addr[31:0], ar_id, ar_len[7:0],
//        ar_size[2:0], ar_burst[1:0]
//   R  : r_valid, r_ready, r_id, r_data[31:0], r_resp[1:0], r_last
//
// Modports
//   master : initiator view (drives request channels, B/R ready)
//   slave  : target view (drives ready of request channels, B/R responses)
// ---------------------------------------------------------------------------
interface axi4 #(
    parameter int idlen = 4
);
    logic             aw_valid;
    logic             aw_ready;
    logic [31:0]      aw_addr;
    logic [idlen-1:0] aw_id;
    logic [7:0]       aw_len;
    logic [2:0]       aw_size;
    logic [1:0]       aw_burst;

    logic             w_valid;
    logic             w_ready;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             w_last;

    logic             b_valid;
    logic             b_ready;
    logic [idlen-1:0] b_id;
    logic [1:0]       b_resp;

    logic             ar_valid;
    logic             ar_ready;
    logic [31:0]      ar_addr;
    logic [idlen-1:0] ar_id;
    logic [7:0]       ar_len;
    logic [2:0]       ar_size;
    logic [1:0]       ar_burst;

    logic             r_valid;
    logic             r_ready;
    logic [idlen-1:0] r_id;
    logic [31:0]      r_data;
    logic [1:0]       r_resp;
    logic             r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/uart_axi_bridge.sv
// ---------------------------------------------------------------------------
// uart_axi_bridge : turns byte commands from a UART receiver into single-beat
// 32-bit AXI4 transactions and returns a status/data reply to the UART
// transmitter.
//
// Command format (bytes, MSB first):
//   write : 'W' A3 A2 A1 A0 D3 D2 D1 D0   -> reply: {6'b0, bresp}
//   read  : 'R' A3 A2 A1 A0               -> reply: {6'b0, rresp} D3 D2 D1 D0
//
// Ports
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   bus      : AXI4 initiator (axi4.master), AxID driven from parameter ID
//   rx_data  : received byte, valid when rx_valid (no backpressure)
//   rx_valid : one-cycle strobe per received byte
//   tx_data  : reply byte, stable while tx_valid && !tx_ready
//   tx_valid : reply byte valid
//   tx_ready : transmitter accepts the byte
//   busy     : high whenever a command is in progress (state != OPC)
//   rx_drop  : registered one-cycle pulse for every discarded rx byte
// ---------------------------------------------------------------------------
module uart_axi_bridge #(
    parameter int unsigned ID = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    axi4.master        bus,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       rx_drop
);

    localparam logic [7:0]  OPC_WRITE = 8'h57;
    localparam logic [7:0]  OPC_READ  = 8'h52;
    localparam logic [31:0] ID_VEC    = ID;

    typedef enum logic [2:0] {
        S_OPC, S_ADDR, S_WDATA, S_AXI_W, S_AXI_B, S_AXI_AR, S_AXI_R, S_RSP
    } state_t;

    state_t      state_q,    state_d;
    logic        is_wr_q,    is_wr_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [1:0]  status_q,   status_d;
    logic        aw_pend_q,  aw_pend_d;
    logic        w_pend_q,   w_pend_d;
    logic        tx_valid_q, tx_valid_d;
    logic [2:0]  tx_idx_q,   tx_idx_d;
    logic        rx_drop_q,  rx_drop_d;

    logic [2:0]  tx_last;

    // Index of the final reply byte: status only for writes, status + 4 data
    // bytes for reads.
    assign tx_last = is_wr_q ? 3'd0 : 3'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OPC;
            is_wr_q    <= 1'b0;
            cnt_q      <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            status_q   <= 2'd0;
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_idx_q   <= 3'd0;
            rx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            aw_pend_q  <= aw_pend_d;
            w_pend_q   <= w_pend_d;
            tx_valid_q <= tx_valid_d;
            tx_idx_q   <= tx_idx_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        tx_valid_d = tx_valid_q;
        tx_idx_d   = tx_idx_q;
        rx_drop_d  = 1'b0;

        case (state_q)
            S_OPC: begin
                if (rx_valid) begin
                    if (rx_data == OPC_WRITE || rx_data == OPC_READ) begin
                        is_wr_d = (rx_data == OPC_WRITE);
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        rx_drop_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d = {addr_q[23:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;   // wraps back to 0 after byte 4
                    if (cnt_q == 2'd3) begin
                        state_d = is_wr_q ? S_WDATA : S_AXI_AR;
                    end
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d   = S_AXI_W;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end
            S_AXI_W: begin
                rx_drop_d = rx_valid;
                // AW and W complete independently; leave once both are done.
                if (aw_pend_q && bus.aw_ready) aw_pend_d = 1'b0;
                if (w_pend_q && bus.w_ready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)   state_d   = S_AXI_B;
            end
            S_AXI_B: begin
                rx_drop_d = rx_valid;
                if (bus.b_valid) begin
                    status_d   = bus.b_resp;
                    tx_valid_d = 1'b0;
                    tx_idx_d   = 3'd0;
                    state_d    = S_RSP;
                end
            end
            S_AXI_AR: begin
                rx_drop_d = rx_valid;
                if (bus.ar_ready) state_d = S_AXI_R;
            end
            S_AXI_R: begin
                rx_drop_d = rx_valid;
                if (bus.r_valid) begin
                    rdata_d    = bus.r_data;
                    status_d   = bus.r_resp;
                    tx_valid_d = 1'b0;
                    tx_idx_d   = 3'd0;
                    state_d    = S_RSP;
                end
            end
            S_RSP: begin
                rx_drop_d = rx_valid;
                // First RSP cycle only raises tx_valid; afterwards each
                // accepted byte advances to the next one.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    if (tx_idx_q == tx_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_OPC;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_OPC;
        endcase
    end

    always_comb begin
        tx_data = {6'b0, status_q};
        case (tx_idx_q)
            3'd1:    tx_data = rdata_q[31:24];
            3'd2:    tx_data = rdata_q[23:16];
            3'd3:    tx_data = rdata_q[15:8];
            3'd4:    tx_data = rdata_q[7:0];
            default: tx_data = {6'b0, status_q};
        endcase
    end

    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != S_OPC);
    assign rx_drop  = rx_drop_q;

    // Write channel
    assign bus.aw_valid = aw_pend_q && (state_q == S_AXI_W);
    assign bus.aw_addr  = addr_q;
    assign bus.aw_id    = ID_VEC[$bits(bus.aw_id)-1:0];
    assign bus.aw_len   = 8'd0;
    assign bus.aw_size  = 3'b010;
    assign bus.aw_burst = 2'b01;
    assign bus.w_valid  = w_pend_q && (state_q == S_AXI_W);
    assign bus.w_data   = wdata_q;
    assign bus.w_strb   = 4'hF;
    assign bus.w_last   = 1'b1;
    assign bus.b_ready  = (state_q == S_AXI_B);

    // Read channel
    assign bus.ar_valid = (state_q == S_AXI_AR);
    assign bus.ar_addr  = addr_q;
    assign bus.ar_id    = ID_VEC[$bits(bus.ar_id)-1:0];
    assign bus.ar_len   = 8'd0;
    assign bus.ar_size  = 3'b010;
    assign bus.ar_burst = 2'b01;
    assign bus.r_ready  = (state_q == S_AXI_R);

    // Response IDs and r_last carry no information for single outstanding
    // single-beat transfers.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{bus.b_id, bus.r_id, bus.r_last};

endmodule

// File: tb/tb_uart_axi_bridge.sv
`timescale 1ns/1ps
module tb_uart_axi_bridge;

    localparam int unsigned TB_ID = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       rx_drop;

    always #5 clk = ~clk;

    axi4 #(.idlen(4)) bus ();

    uart_axi_bridge #(.ID(TB_ID)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .rx_drop  (rx_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: what the bus and the UART side must show.
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [7:0]  exp_tx_q[$];
    int          exp_drop_q[$];
    logic [7:0]  tx_log[$];
    logic [31:0] last_aw_addr = '0, last_w_data = '0, last_ar_addr = '0;
    int          b_hs_count = 0;

    // Slave / transmitter behaviour knobs
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  sl_resp = 2'b00;
    logic [31:0] sl_rdata = '0;
    int          txr_mode = 0;  // 0 always ready, 1 random, 2 every other cycle

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        int  awc, wc, arc, bc, rc;
        bit  got_aw, got_w, got_ar;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.r_valid = 0;
        bus.b_id = 4'(TB_ID); bus.r_id = 4'(TB_ID); bus.r_last = 1'b1;
        bus.b_resp = 0; bus.r_resp = 0; bus.r_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
            end else begin
                if (bus.aw_valid && bus.aw_ready) begin got_aw = 1; awc = 0; end
                else if (bus.aw_valid) awc++;
                if (bus.w_valid && bus.w_ready) begin got_w = 1; wc = 0; end
                else if (bus.w_valid) wc++;
                if (bus.ar_valid && bus.ar_ready) begin got_ar = 1; arc = 0; end
                else if (bus.ar_valid) arc++;
                if (bus.b_valid && bus.b_ready) begin got_aw = 0; got_w = 0; bc = 0; end
                else if (got_aw && got_w) bc++;
                if (bus.r_valid && bus.r_ready) begin got_ar = 0; rc = 0; end
                else if (got_ar) rc++;
            end
            @(posedge clk);
            #1;
            bus.aw_ready = (awc >= aw_dly);
            bus.w_ready  = (wc >= w_dly);
            bus.ar_ready = (arc >= ar_dly);
            bus.b_valid  = got_aw && got_w && (bc >= b_dly);
            bus.r_valid  = got_ar && (rc >= r_dly);
            bus.b_resp   = sl_resp;
            bus.r_resp   = sl_resp;
            bus.r_data   = sl_rdata;
        end
    end

    // ---------------- transmitter ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (txr_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = cyc[0];
            endcase
        end
    end

    // ---------------- compare process ----------------
    initial begin
        bit         aw_done, w_done, ar_done, prev_tx_pend, exp_drop;
        logic [7:0] prev_tx_data;
        aw_done = 0; w_done = 0; ar_done = 0; prev_tx_pend = 0; prev_tx_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready,
                       bus.r_ready, tx_valid, busy, rx_drop}, 0);
                aw_done = 0; w_done = 0; ar_done = 0; prev_tx_pend = 0;
                continue;
            end
            // rx_drop must pulse exactly one cycle after a byte that is discarded
            exp_drop = (exp_drop_q.size() > 0 && exp_drop_q[0] == cyc);
            if (exp_drop) void'(exp_drop_q.pop_front());
            if (rx_drop || exp_drop) check("rx_drop", rx_drop, exp_drop);

            if (bus.aw_valid) begin
                check("aw_reassert", aw_done, 0);
                if (bus.aw_ready) begin
                    if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
                    else check("aw_addr", bus.aw_addr, exp_aw_q.pop_front());
                    check("aw_attr", {bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst},
                          {4'(TB_ID), 8'd0, 3'b010, 2'b01});
                    last_aw_addr = bus.aw_addr;
                    aw_done = 1;
                end
            end
            if (bus.w_valid) begin
                check("w_reassert", w_done, 0);
                if (bus.w_ready) begin
                    if (exp_w_q.size() == 0) fail_now("w_unexpected");
                    else check("w_data", bus.w_data, exp_w_q.pop_front());
                    check("w_attr", {bus.w_strb, bus.w_last}, {4'hF, 1'b1});
                    last_w_data = bus.w_data;
                    w_done = 1;
                end
            end
            if (bus.b_ready) begin
                check("b_ready_ctx", {aw_done, w_done}, 2'b11);
                if (bus.b_valid) begin aw_done = 0; w_done = 0; b_hs_count++; end
            end
            if (bus.ar_valid) begin
                check("ar_reassert", ar_done, 0);
                if (bus.ar_ready) begin
                    if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
                    else check("ar_addr", bus.ar_addr, exp_ar_q.pop_front());
                    check("ar_attr", {bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst},
                          {4'(TB_ID), 8'd0, 3'b010, 2'b01});
                    last_ar_addr = bus.ar_addr;
                    ar_done = 1;
                end
            end
            if (bus.r_ready) begin
                check("r_ready_ctx", ar_done, 1);
                if (bus.r_valid) ar_done = 0;
            end

            if (prev_tx_pend) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_tx_data});
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) fail_now("tx_unexpected");
                else check("tx_byte", tx_data, exp_tx_q.pop_front());
                tx_log.push_back(tx_data);
                prev_tx_pend = 0;
            end else if (tx_valid) begin
                prev_tx_pend = 1;
                prev_tx_data = tx_data;
            end else begin
                prev_tx_pend = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit will_drop);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        if (will_drop) exp_drop_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] garbage_byte();
        logic [7:0] g;
        do g = 8'($urandom); while (g == 8'h57 || g == 8'h52);
        return g;
    endfunction

    task automatic send_cmd(input bit is_w, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input logic [31:0] rdata,
                            input bit garbage_before, input bit extra_after);
        int k;
        sl_resp  = resp;
        sl_rdata = rdata;
        if (garbage_before) send_byte(garbage_byte(), 1);
        if (is_w) begin
            exp_aw_q.push_back(addr);
            exp_w_q.push_back(data);
        end else begin
            exp_ar_q.push_back(addr);
        end
        exp_tx_q.push_back({6'b0, resp});
        if (!is_w) for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rdata[8*i +: 8]);

        send_byte(is_w ? 8'h57 : 8'h52, 0);
        check("busy_after_opcode", busy, 1);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], 0);
        if (is_w) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], 0);
        if (extra_after) send_byte(8'($urandom), 1);

        k = 0;
        while (!(exp_tx_q.size() == 0 && !busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            fail_now("cmd_timeout");
            exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_tx_q.delete();
        end
        check("axi_expect_drained", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
    endtask

    task automatic set_delays(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_tx_valid", tx_valid, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed write
        set_delays(0, 0, 0, 0, 0); txr_mode = 0; tx_log.delete();
        send_cmd(1, 32'h00010004, 32'h00000A2C, 2'b00, 32'h0, 0, 0);
        check("wr_aw_addr_lit", last_aw_addr, 32'h00010004);
        check("wr_w_data_lit", last_w_data, 32'h00000A2C);
        check("wr_tx_len", tx_log.size(), 1);
        if (tx_log.size() == 1) check("wr_tx_lit", tx_log[0], 8'h00);

        // Directed read
        tx_log.delete();
        send_cmd(0, 32'h0001001C, 32'h0, 2'b00, 32'h00010203, 0, 0);
        check("rd_ar_addr_lit", last_ar_addr, 32'h0001001C);
        check("rd_tx_len", tx_log.size(), 5);
        if (tx_log.size() == 5)
            check("rd_tx_lit", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]},
                  40'h00_00_01_02_03);

        // Split handshake: W accepted three cycles before AW
        set_delays(3, 0, 0, 1, 0);
        b0 = b_hs_count;
        send_cmd(1, 32'h12345678, 32'hCAFEF00D, 2'b00, 32'h0, 0, 0);
        check("split_single_b", b_hs_count - b0, 1);

        // SLVERR read with transmitter backpressure
        set_delays(0, 0, 1, 0, 2); txr_mode = 2; tx_log.delete();
        send_cmd(0, 32'hA0000010, 32'h0, 2'b10, 32'hDEADBEEF, 0, 0);
        check("err_tx_len", tx_log.size(), 5);
        if (tx_log.size() == 5)
            check("err_tx_lit", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]},
                  40'h02_DE_AD_BE_EF);

        // Garbage in OPC and an extra byte while waiting for R
        set_delays(0, 0, 0, 0, 6); txr_mode = 0;
        send_cmd(0, 32'h00000040, 32'h0, 2'b00, 32'h55AA33CC, 1, 1);

        // Reset in the middle of the address phase
        send_byte(8'h52, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_tx_expect", exp_tx_q.size(), 0);
        send_cmd(0, 32'h0BADC0DE, 32'h0, 2'b00, 32'h01020304, 0, 0);
        check("post_rst_ar_lit", last_ar_addr, 32'h0BADC0DE);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 4));
            txr_mode = $urandom_range(0, 2);
            send_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                     $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check("drops_all_seen", exp_drop_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_axi_bridge.md
UART_AXI_BRIDGE -- requirements
Module: uart_axi_bridge

Interface
REQ-001 Parameter ID, default 0: AXI ID driven on aw.id/ar.id; width bus.idlen.
REQ-002 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-003 bus  axi4.master  --  AXI4 initiator port; single-beat 32-bit transactions only.
REQ-004 rx_data  input  8  byte received from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure.
REQ-006 tx_data  output  8  byte to UART transmitter.
REQ-007 tx_valid  output  1  tx_data valid; held with tx_data stable until tx_ready.
REQ-008 tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
REQ-009 busy  output  1  high in every state except OPC.
REQ-010 rx_drop  output  1  one-cycle pulse when an rx byte is discarded.

Function
REQ-011 States: OPC, ADDR, WDATA, AXI_W, AXI_B, AXI_AR, AXI_R, RSP.
REQ-012 OPC: on rx_valid, byte 0x57 ('W') or 0x52 ('R') latches opcode and goes to ADDR; any other byte is dropped, stays in OPC, pulses rx_drop.
REQ-013 ADDR: collects 4 bytes, MSB first, into a 32-bit address; 2-bit byte counter; after the 4th byte goes to WDATA if 'W', else AXI_AR.
REQ-014 WDATA: collects 4 bytes, MSB first, into wdata; after the 4th byte goes to AXI_W.
REQ-015 rx_valid in any state other than OPC/ADDR/WDATA: byte dropped, rx_drop pulsed, state unaffected.
REQ-016 AXI_W: aw_valid and w_valid asserted on state entry; each deasserts independently after its own handshake, never reasserted in the same transaction; both done -> AXI_B.
REQ-017 Write attributes: aw.addr=address, aw.id=ID, aw.len=0, aw.size=3'b010, aw.burst=INCR; w.data=wdata, w.strb=4'hF, w.last=1.
REQ-018 AXI_B: b_ready=1; on b_valid latches b.resp into status and goes to RSP.
REQ-019 AXI_AR: ar_valid=1 with ar.addr=address, ar.id=ID, ar.len=0, ar.size=3'b010, ar.burst=INCR; on ar_ready -> AXI_R.
REQ-020 AXI_R: r_ready=1; on r_valid latches r.data and r.resp and goes to RSP; r.last not checked.
REQ-021 No AXI valid is asserted outside AXI_W/AXI_AR; b_ready/r_ready are 0 outside AXI_B/AXI_R.
REQ-022 RSP: sends status byte {6'b0, resp}; for reads then 4 data bytes MSB first; write reply 1 byte, read reply 5 bytes; after last accepted byte -> OPC.
REQ-023 tx_valid rises no earlier than the cycle after RSP entry; next byte presented the cycle after each handshake; tx_ready ignored when tx_valid=0.
REQ-024 rx_drop is registered: pulses the cycle after the dropped rx_valid.
REQ-025 Responses with SLVERR/DECERR are relayed, never retried; read data relayed unmodified.
REQ-026 Only one transaction outstanding; no AXI timeout (hung slave holds busy=1 until reset).

Reset
REQ-027 Async reset: state=OPC, byte counter=0, address/wdata/read-data/status=0.
REQ-028 During reset: all AXI valids/readys=0, tx_valid=0, busy=0, rx_drop=0.
REQ-029 Reset mid-transaction abandons it; no reply byte is sent after release.

Verification
REQ-030 Write: rx 57 00 01 00 04 00 00 0A 2C, slave OKAY -> aw.addr=0x00010004, w.data=0x00000A2C, strb=F; tx 00.
REQ-031 Read: rx 52 00 01 00 1C, slave returns 0x00010203 OKAY -> ar.addr=0x0001001C; tx 00 00 01 02 03.
REQ-032 Split handshake: write with w_ready 3 cycles before aw_ready -> w_valid drops after its handshake, aw_valid held, single B accepted.
REQ-033 Error/backpressure: read returning SLVERR, tx_ready toggled every other cycle -> tx 02 then data bytes, each held stable until accepted.
REQ-034 Garbage/drop: rx 0x41 in OPC, extra byte during AXI_R -> rx_drop pulse each, following valid command processed normally.
REQ-035 Reset mid-ADDR after 2 bytes -> state OPC; next full read command yields correct address.
